// File: rtl/jts16b_pkg.sv
// rtl/jts16b_pkg.sv - shared types and constants for the sound command path
// Holds the fetch FSM state encoding, the FIFO depth used when
// JTS16B_SNDFIFO_EN is defined, and the status-byte bit positions.
package jts16b_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_SETTLE = 2'd2
    } snd_state_e;

    localparam int SNDFIFO_DEPTH = 4;

    // Status byte layout: {~empty, full, map_obf, 2'b0, level[2:0]}
    localparam int STAT_NEMPTY  = 7;
    localparam int STAT_FULL    = 6;
    localparam int STAT_OBF     = 5;
    localparam int STAT_LVL_MSB = 2;

endpackage

// File: rtl/jts16b_sndfifo.sv
// rtl/jts16b_sndfifo.sv - byte storage for sound commands (FIFO or single register)
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push_i, din_i     write one byte (ignored when full)
//   pop_i             drop the head entry (ignored when empty)
//   head_o            current head entry
//   level_o           entries held, 0..DEPTH
//   empty_o, full_o   occupancy flags
module jts16b_sndfifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [7:0] din_i,
    input  logic       pop_i,
    output logic [7:0] head_o,
    output logic [2:0] level_o,
    output logic       empty_o,
    output logic       full_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem_q [0:(1<<AW)-1];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW-1:0] wr_ptr_d, rd_ptr_d;
    logic [2:0]    level_q;
    logic          do_push, do_pop;

    assign empty_o = (level_q == 3'd0);
    assign full_o  = (level_q == 3'(DEPTH));
    assign level_o = level_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap at DEPTH-1 explicitly so non-power-of-two depths
    // (including the single-register build) never skip a slot.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= 3'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 3'd1;
                2'b01:   level_q <= level_q - 3'd1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/jts16b_sndcmd.sv
// rtl/jts16b_sndcmd.sv - mapper-to-Z80 sound command latch with fetch FSM
// Pulls bytes from the mapper sound latch into local storage and presents
// them to the sound Z80 on an I/O port, raising INT or NMI while data waits.
// Macro JTS16B_SNDFIFO_EN: defined -> 4-entry FIFO, undefined -> one byte.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   map_obf, map_dout    mapper latch full flag and data
//   map_rd               one-cycle strobe that consumes the mapper byte
//   snd_cs, snd_addr0    Z80 port read (level) and data/status select
//   snd_dout             data or status byte to Z80 (combinational)
//   snd_intn, snd_nmin   Z80 interrupt lines, active low
//   level                entries held
module jts16b_sndcmd
    import jts16b_pkg::*;
#(
    parameter int NMI_MODE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       map_obf,
    input  logic [7:0] map_dout,
    output logic       map_rd,
    input  logic       snd_cs,
    input  logic       snd_addr0,
    output logic [7:0] snd_dout,
    output logic       snd_intn,
    output logic       snd_nmin,
    output logic [2:0] level
);

`ifdef JTS16B_SNDFIFO_EN
    localparam int DEPTH = SNDFIFO_DEPTH;
`else
    localparam int DEPTH = 1;
`endif

    snd_state_e state_q, state_d;
    logic       cs_q, addr0_q;
    logic [7:0] hold_q;
    logic       intn_q, nmin_q;
    logic       push, pop;
    logic       empty, full, empty_d;
    logic [7:0] head;
    logic [7:0] status;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (map_obf && !full) state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_SETTLE;
            // map_obf is ignored here: the mapper is still clearing it
            ST_SETTLE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Gated by rst so a reset landing in FETCH neither consumes the
    // mapper byte nor stores it; the mapper keeps obf and we refetch.
    assign map_rd = (state_q == ST_FETCH) && !rst;
    assign push   = map_rd;

    // Pop on the falling edge of a data-port read cycle.
    assign pop = cs_q && !snd_cs && !addr0_q && !empty;

    // Emptiness after this edge, so snd_intn tracks storage one clk later.
    assign empty_d = (empty && !push) || ((level == 3'd1) && pop && !push);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cs_q    <= 1'b0;
            addr0_q <= 1'b0;
            hold_q  <= 8'h00;
            intn_q  <= 1'b1;
            nmin_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cs_q    <= snd_cs;
            addr0_q <= snd_addr0;
            if (pop) hold_q <= head;
            intn_q  <= (NMI_MODE == 0) ? empty_d : 1'b1;
            nmin_q  <= (NMI_MODE == 1) ? !push : 1'b1;
        end
    end

    jts16b_sndfifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (map_dout),
        .pop_i   (pop),
        .head_o  (head),
        .level_o (level),
        .empty_o (empty),
        .full_o  (full)
    );

    always_comb begin
        status                  = 8'h00;
        status[STAT_NEMPTY]     = ~empty;
        status[STAT_FULL]       = full;
        status[STAT_OBF]        = map_obf;
        status[STAT_LVL_MSB:0]  = level;
    end

    // Empty storage returns the last byte popped.
    assign snd_dout = snd_addr0 ? status : (empty ? hold_q : head);
    assign snd_intn = intn_q;
    assign snd_nmin = nmin_q;

endmodule

// File: tb/tb_jts16b_sndcmd.sv
// tb/tb_jts16b_sndcmd.sv - scoreboard bench for jts16b_sndcmd (INT and NMI instances)
module tb_jts16b_sndcmd;

`ifdef JTS16B_SNDFIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk, rst;
    logic       map_obf;
    logic [7:0] map_dout;
    logic       snd_cs, snd_addr0;
    logic       map_rd, snd_intn, snd_nmin;
    logic [7:0] snd_dout;
    logic [2:0] level;
    logic       n_map_rd, n_intn, n_nmin;
    logic [7:0] n_dout;
    logic [2:0] n_level;

    int checks = 0;
    int errors = 0;

    logic [7:0] mw_q[$];   // bytes the mapper will still post
    logic [7:0] exp_q[$];  // bytes posted and not yet popped, in order
    int         n_stored = 0;
    logic [7:0] last_pop = 8'h00;
    logic       cs_prev = 1'b0, addr_prev = 1'b0, push_prev = 1'b0, rd_prev = 1'b0;
    int         stall = 0;
    logic       rd_seen;

    jts16b_sndcmd #(.NMI_MODE(0)) u_dut (
        .clk(clk), .rst(rst), .map_obf(map_obf), .map_dout(map_dout),
        .map_rd(map_rd), .snd_cs(snd_cs), .snd_addr0(snd_addr0),
        .snd_dout(snd_dout), .snd_intn(snd_intn), .snd_nmin(snd_nmin),
        .level(level)
    );

    jts16b_sndcmd #(.NMI_MODE(1)) u_nmi (
        .clk(clk), .rst(rst), .map_obf(map_obf), .map_dout(map_dout),
        .map_rd(n_map_rd), .snd_cs(snd_cs), .snd_addr0(snd_addr0),
        .snd_dout(n_dout), .snd_intn(n_intn), .snd_nmin(n_nmin),
        .level(n_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic timeout_fail(string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event t=%0t", name, $time);
    endtask

    // Mapper: posts queued bytes one at a time, clears obf when strobed.
    initial begin
        map_obf  = 1'b0;
        map_dout = 8'h00;
        forever begin
            @(negedge clk);
            rd_seen = map_rd;
            @(posedge clk);
            #1;
            if (rd_seen) map_obf = 1'b0;
            if (!map_obf && mw_q.size() > 0) begin
                map_dout = mw_q.pop_front();
                map_obf  = 1'b1;
                exp_q.push_back(map_dout);
            end
        end
    end

    // Monitor: compares DUT outputs to the model, then applies the
    // transfers that the coming edge will perform.
    always @(negedge clk) begin
        logic [7:0] stat_exp;
        logic       do_pop;
        if (rst) begin
            for (int i = 0; i < n_stored; i++) void'(exp_q.pop_front());
            n_stored  = 0;
            last_pop  = 8'h00;
            cs_prev   = 1'b0;
            addr_prev = 1'b0;
            push_prev = 1'b0;
            rd_prev   = 1'b0;
            stall     = 0;
        end else begin
            check("level", int'(level), n_stored);
            check("intn", int'(snd_intn), (n_stored == 0) ? 1 : 0);
            check("nmin_int_mode", int'(snd_nmin), 1);
            check("intn_nmi_mode", int'(n_intn), 1);
            check("nmin_pulse", int'(n_nmin), push_prev ? 0 : 1);
            if (map_rd) begin
                check("rd_when_full", (n_stored < DEPTH) ? 1 : 0, 1);
                check("rd_one_clk", int'(rd_prev), 0);
            end
            if (map_obf && !map_rd && n_stored < DEPTH) stall++;
            else stall = 0;
            if (stall > 3) check("fetch_latency", stall, 3);
            if (snd_cs) begin
                if (!snd_addr0) begin
                    check("data", int'(snd_dout), int'((n_stored > 0) ? exp_q[0] : last_pop));
                end else begin
                    stat_exp = {(n_stored != 0), (n_stored == DEPTH), map_obf, 2'b00, 3'(n_stored)};
                    check("status", int'(snd_dout), int'(stat_exp));
                end
            end
            do_pop = cs_prev && !snd_cs && !addr_prev && (n_stored > 0);
            if (do_pop) begin
                last_pop = exp_q.pop_front();
                n_stored--;
            end
            if (map_rd) n_stored++;
            push_prev = map_rd;
            rd_prev   = map_rd;
            cs_prev   = snd_cs;
            addr_prev = snd_addr0;
        end
    end

    task automatic z80_read(input logic a, input int hold);
        @(posedge clk);
        #1;
        snd_cs    = 1'b1;
        snd_addr0 = a;
        repeat (hold) @(posedge clk);
        #1;
        snd_cs = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (level == 3'd0 && !map_obf && mw_q.size() == 0) return;
            if (level != 3'd0) z80_read(1'b0, 1);
        end
        timeout_fail("drain");
    endtask

    task automatic wait_rd(string name);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (map_rd) return;
        end
        timeout_fail(name);
    endtask

    initial begin
        rst       = 1'b1;
        snd_cs    = 1'b0;
        snd_addr0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_map_rd", int'(map_rd), 0);
        check("reset_dout", int'(snd_dout), 0);

        // single byte, then empty read and status read
        mw_q.push_back(8'h5A);
        repeat (8) @(posedge clk);
        z80_read(1'b0, 1);
        repeat (2) @(posedge clk);
        z80_read(1'b0, 2);
        z80_read(1'b1, 1);
        @(negedge clk);
        check("after_empty_read_level", int'(level), 0);

        // backpressure: five bytes, no reads
        for (int b = 1; b <= 5; b++) mw_q.push_back(8'(b));
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("bp_level", int'(level), DEPTH);
        check("bp_obf", int'(map_obf), 1);
        z80_read(1'b1, 1);
        drain();

        // randomized mix of mapper posts and port reads
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(2, 0) == 0 && mw_q.size() < 3) mw_q.push_back(8'($urandom));
            case ($urandom_range(3, 0))
                0, 1: z80_read(1'b0, $urandom_range(3, 1));
                2:    z80_read(1'b1, $urandom_range(2, 1));
                default: repeat ($urandom_range(3, 1)) @(posedge clk);
            endcase
        end
        drain();

        // reset during FETCH: byte must be refetched afterwards
        mw_q.push_back(8'hC3);
        wait_rd("first_fetch");
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_map_rd", int'(map_rd), 0);
        check("rst_level", int'(level), 0);
        check("rst_intn", int'(snd_intn), 1);
        check("rst_obf_kept", int'(map_obf), 1);
        rst = 1'b0;
        wait_rd("refetch");
        drain();

        repeat (5) @(posedge clk);
        check("leftover", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
